// File: rtl/adif_chk_pkg.sv
// Shared types and constants for the analog-interface mode checker.
// Holds the per-mode FSM state encoding, 2-bit result codes and mode indices.
package adif_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } mode_state_e;

  localparam logic [1:0] STAT_NA   = 2'd0;
  localparam logic [1:0] STAT_NOE  = 2'd1;
  localparam logic [1:0] STAT_PASS = 2'd2;
  localparam logic [1:0] STAT_FAIL = 2'd3;

  localparam int MODE_POR     = 0;
  localparam int MODE_ATPG    = 1;
  localparam int MODE_SUSPEND = 2;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Next history code for one entry; a FAIL is never downgraded by a later match.
  function automatic logic [1:0] next_hist(input logic [1:0] hist,
                                           input logic       compared,
                                           input logic       mismatch);
    logic [1:0] res;
    res = hist;
    if (mismatch) begin
      res = STAT_FAIL;
    end else if (compared && (hist != STAT_FAIL)) begin
      res = STAT_PASS;
    end
    return res;
  endfunction

endpackage

// File: rtl/adif_mode_fsm.sv
// One check mode: IDLE -> SETTLE (STROBE_CYC qualifying cycles) -> ACTIVE.
// active is a registered flag, high exactly while the FSM sits in ACTIVE.
module adif_mode_fsm
  import adif_chk_pkg::*;
#(
  parameter int STROBE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_cond,
  output logic active
);

  localparam int CW = $clog2(STROBE_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_STROBE = CW'(STROBE_CYC);

  mode_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_cond) begin
          cnt_d   = CNT_ONE;
          state_d = (cnt_d == CNT_STROBE) ? ST_ACTIVE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!mode_cond) begin
          // Any drop during settle abandons the attempt; the next rise starts over.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_STROBE) begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (!mode_cond) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d == ST_ACTIVE);
    end
  end

  assign active = active_q;

endmodule

// File: rtl/adif_mode_checker.sv
// Compares analog-interface channel values against per-mode golden values while each mode is ACTIVE.
// Results (status, err_cnt, first_fail) land one cycle after the compared cycle; no backpressure.
module adif_mode_checker
  import adif_chk_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int W          = 4,
  parameter int NMODE      = 3,
  parameter int STROBE_CYC = 20,
  localparam int MW        = (NMODE > 1) ? $clog2(NMODE) : 1,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*W-1:0]         da_val,
  input  logic [NMODE-1:0]         mode_cond,
  input  logic [NMODE*NCH*W-1:0]   golden,
  input  logic [NMODE*NCH-1:0]     chk_mask,
  input  logic                     clr,
  output logic [NMODE-1:0]         mode_active,
  output logic [NMODE*NCH*2-1:0]   status,
  output logic [15:0]              err_cnt,
  output logic                     first_fail_vld,
  output logic [MW-1:0]            first_fail_mode,
  output logic [CHW-1:0]           first_fail_ch,
  output logic [W-1:0]             first_fail_val,
  output logic                     any_fail
);

  localparam int NENT = NMODE * NCH;

  logic [NMODE-1:0]    act;
  logic [NENT-1:0]     cmp;
  logic [NENT-1:0]     mis;
  logic [NENT*2-1:0]   hist_q, hist_d;
  logic [15:0]         err_q, err_d;
  logic                ff_vld_q, ff_vld_d;
  logic [MW-1:0]       ff_mode_q, ff_mode_d;
  logic [CHW-1:0]      ff_ch_q, ff_ch_d;
  logic [W-1:0]        ff_val_q, ff_val_d;
  logic                hit;
  logic [MW-1:0]       hit_mode;
  logic [CHW-1:0]      hit_ch;
  logic [W-1:0]        hit_val;

  for (genvar m = 0; m < NMODE; m++) begin : g_fsm
    adif_mode_fsm #(
      .STROBE_CYC(STROBE_CYC)
    ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .mode_cond(mode_cond[m]),
      .active   (act[m])
    );
  end

  assign mode_active = act;

  always_comb begin
    cmp = '0;
    mis = '0;
    for (int m = 0; m < NMODE; m++) begin
      for (int c = 0; c < NCH; c++) begin
        cmp[m*NCH+c] = act[m] & chk_mask[m*NCH+c];
        mis[m*NCH+c] = cmp[m*NCH+c] &
                       (da_val[c*W +: W] != golden[(m*NCH+c)*W +: W]);
      end
    end
  end

  // Mode-major scan so the lowest mode, then lowest channel, wins a tie.
  always_comb begin
    hit      = 1'b0;
    hit_mode = '0;
    hit_ch   = '0;
    hit_val  = '0;
    for (int m = 0; m < NMODE; m++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!hit && mis[m*NCH+c]) begin
          hit      = 1'b1;
          hit_mode = MW'(m);
          hit_ch   = CHW'(c);
          hit_val  = da_val[c*W +: W];
        end
      end
    end
  end

  always_comb begin
    hist_d = hist_q;
    for (int i = 0; i < NENT; i++) begin
      if (clr) begin
        if (chk_mask[i]) begin
          hist_d[i*2 +: 2] = STAT_NOE;
        end
      end else begin
        hist_d[i*2 +: 2] = next_hist(hist_q[i*2 +: 2], cmp[i], mis[i]);
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = '0;
    end else if ((|mis) && (err_q != ERR_CNT_MAX)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_comb begin
    ff_vld_d  = ff_vld_q;
    ff_mode_d = ff_mode_q;
    ff_ch_d   = ff_ch_q;
    ff_val_d  = ff_val_q;
    if (clr) begin
      ff_vld_d  = 1'b0;
      ff_mode_d = '0;
      ff_ch_d   = '0;
      ff_val_d  = '0;
    end else if (!ff_vld_q && hit) begin
      ff_vld_d  = 1'b1;
      ff_mode_d = hit_mode;
      ff_ch_d   = hit_ch;
      ff_val_d  = hit_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= {NENT{STAT_NOE}};
      err_q     <= '0;
      ff_vld_q  <= 1'b0;
      ff_mode_q <= '0;
      ff_ch_q   <= '0;
      ff_val_q  <= '0;
    end else begin
      hist_q    <= hist_d;
      err_q     <= err_d;
      ff_vld_q  <= ff_vld_d;
      ff_mode_q <= ff_mode_d;
      ff_ch_q   <= ff_ch_d;
      ff_val_q  <= ff_val_d;
    end
  end

  // History survives masking; the mask only decides what is reported.
  always_comb begin
    status   = '0;
    any_fail = 1'b0;
    for (int i = 0; i < NENT; i++) begin
      status[i*2 +: 2] = chk_mask[i] ? hist_q[i*2 +: 2] : STAT_NA;
      any_fail         = any_fail | (status[i*2 +: 2] == STAT_FAIL);
    end
  end

  assign err_cnt         = err_q;
  assign first_fail_vld  = ff_vld_q;
  assign first_fail_mode = ff_mode_q;
  assign first_fail_ch   = ff_ch_q;
  assign first_fail_val  = ff_val_q;

endmodule
